// File: rtl/ex_mem_pkg.sv
// Shared core definitions used by the EX/MEM pipeline register: bus widths,
// stall-vector layout, reset level and the slot-update decode.
package ex_mem_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned StallW     = 6;
  localparam int unsigned StallEx    = 3;
  localparam int unsigned StallMem   = 4;

  localparam logic RstEnable    = 1'b0;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold,
    ActFlush
  } slot_act_e;

  // Flush beats any stall; ex-stall with mem-stall clear is the only bubble case.
  function automatic slot_act_e decode_act(input logic flush, input logic ex_stall,
                                           input logic mem_stall);
    if (flush) return ActFlush;
    if (ex_stall && !mem_stall) return ActBubble;
    if (ex_stall) return ActHold;
    return ActLoad;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM boundary bundle: ctrl stall/flush, execute results in, registered
// memory-stage results and multi-cycle feedback out.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PERF_W = 16
);

  logic [StallW-1:0]   stall;
  logic                flush;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] hilo_i;
  logic [CNT_W-1:0]    cnt_i;
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic [2*DATA_W-1:0] hilo_o;
  logic [CNT_W-1:0]    cnt_o;
  logic [PERF_W-1:0]   bubble_cnt;

  modport master (
    output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o, bubble_cnt
  );

  modport slave (
    input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o, bubble_cnt
  );

endinterface

// File: rtl/ex_mem_perf_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; sticks at
// all-ones instead of wrapping.
module ex_mem_perf_sat_counter
  import ex_mem_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + Width'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) count_q <= '0;
    else                  count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register of the MIPS32 core: captures execute results,
// inserts bubbles / holds / flushes, and loops MADD temporaries back to ex.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PERF_W = 16
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  slot_act_e act;
  logic      unused_stall;

  logic [ADDR_W-1:0]   wd_q, wd_d;
  logic                wreg_q, wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                whilo_q, whilo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign act          = decode_act(bus.flush, bus.stall[StallEx], bus.stall[StallMem]);
  assign unused_stall = ^{bus.stall[5], bus.stall[2:0]};

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    unique case (act)
      ActFlush, ActBubble: begin
        wd_d    = '0;
        wreg_d  = WriteDisable;
        wdata_d = '0;
        whilo_d = WriteDisable;
        hi_d    = '0;
        lo_d    = '0;
        // Only a bubble keeps the MADD temporaries alive for the stalled ex.
        hilo_d  = (act == ActBubble) ? bus.hilo_i : '0;
        cnt_d   = (act == ActBubble) ? bus.cnt_i : '0;
      end
      ActHold: ;
      ActLoad: begin
        wd_d    = bus.ex_wd;
        wreg_d  = bus.ex_wreg;
        wdata_d = bus.ex_wdata;
        whilo_d = bus.ex_whilo;
        hi_d    = bus.ex_hi;
        lo_d    = bus.ex_lo;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wd_q    <= '0;
      wreg_q  <= WriteDisable;
      wdata_q <= '0;
      whilo_q <= WriteDisable;
      hi_q    <= '0;
      lo_q    <= '0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  ex_mem_perf_sat_counter #(
    .Width(PERF_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (act == ActBubble),
    .count(bus.bubble_cnt)
  );

  assign bus.mem_wd    = wd_q;
  assign bus.mem_wreg  = wreg_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_whilo = whilo_q;
  assign bus.mem_hi    = hi_q;
  assign bus.mem_lo    = lo_q;
  assign bus.hilo_o    = hilo_q;
  assign bus.cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: the driver queues hand-computed expectations,
// the monitor pops and compares them one per clock on the falling edge.
module tb_ex_mem;

  typedef struct {
    bit          chk;
    string       name;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [15:0] bub;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mem_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .PERF_W(16)) bus ();

  ex_mem #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .PERF_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ctrl must never request mem-stall while ex advances
  always @(posedge clk)
    if (rst) assert (!(!bus.stall[3] && bus.stall[4])) else $error("illegal stall vector");

  function automatic exp_t mk(string nm, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                              logic whilo, logic [31:0] hi, logic [31:0] lo,
                              logic [63:0] hilo, logic [1:0] cnt, logic [15:0] bub);
    exp_t e;
    e.chk = 1'b1; e.name = nm; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo;
    e.hi = hi; e.lo = lo; e.hilo = hilo; e.cnt = cnt; e.bub = bub;
    return e;
  endfunction

  task automatic cmp(string nm, string f, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, f, act, exp);
    end
  endtask

  task automatic check_rec(exp_t e);
    cmp(e.name, "mem_wd", 64'(bus.mem_wd), 64'(e.wd));
    cmp(e.name, "mem_wreg", 64'(bus.mem_wreg), 64'(e.wreg));
    cmp(e.name, "mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
    cmp(e.name, "mem_whilo", 64'(bus.mem_whilo), 64'(e.whilo));
    cmp(e.name, "mem_hi", 64'(bus.mem_hi), 64'(e.hi));
    cmp(e.name, "mem_lo", 64'(bus.mem_lo), 64'(e.lo));
    cmp(e.name, "hilo_o", bus.hilo_o, e.hilo);
    cmp(e.name, "cnt_o", 64'(bus.cnt_o), 64'(e.cnt));
    cmp(e.name, "bubble_cnt", 64'(bus.bubble_cnt), 64'(e.bub));
  endtask

  task automatic check_zero(string nm);
    check_rec(mk(nm, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0, '0));
  endtask

  task automatic drive(logic [5:0] st, logic fl, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                       logic whilo, logic [31:0] hi, logic [31:0] lo, logic [63:0] hilo,
                       logic [1:0] cnt);
    bus.stall = st; bus.flush = fl; bus.ex_wd = wd; bus.ex_wreg = wreg; bus.ex_wdata = wdata;
    bus.ex_whilo = whilo; bus.ex_hi = hi; bus.ex_lo = lo; bus.hilo_i = hilo; bus.cnt_i = cnt;
  endtask

  // One clock of stimulus; e describes the outputs after the following rising edge.
  task automatic cyc(logic [5:0] st, logic fl, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                     logic whilo, logic [31:0] hi, logic [31:0] lo, logic [63:0] hilo,
                     logic [1:0] cnt, exp_t e);
    @(negedge clk);
    #1;
    drive(st, fl, wd, wreg, wdata, whilo, hi, lo, hilo, cnt);
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        if (me.chk) check_rec(me);
      end
    end
  end

  initial begin : driver
    exp_t skip;
    int   waited;
    skip.chk = 1'b0;
    drive('0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check_zero("reset");
    #1 rst = 1'b1;

    cyc(6'b000000, 0, 5'd5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0,
        mk("pass", 5'd5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
    cyc(6'b000000, 0, 5'd0, 0, 32'h0, 1, 32'h1234, 32'h5678, 0, 0,
        mk("hilo", 5'd0, 0, 32'h0, 1, 32'h1234, 32'h5678, 0, 0, 0));
    cyc(6'b001111, 0, 5'd7, 1, 32'h1111, 0, 0, 0, 64'h0000_0001_0000_0002, 2'd1,
        mk("madd_bub", 5'd0, 0, 0, 0, 0, 0, 64'h0000_0001_0000_0002, 2'd1, 16'd1));
    cyc(6'b000000, 0, 5'd7, 1, 32'h1111, 0, 0, 0, 64'h0000_0001_0000_0002, 2'd1,
        mk("madd_adv", 5'd7, 1, 32'h1111, 0, 0, 0, 0, 0, 16'd1));
    cyc(6'b000000, 0, 5'd9, 1, 32'hA5A5A5A5, 1, 32'hAAAA, 32'hBBBB, 0, 0,
        mk("load", 5'd9, 1, 32'hA5A5A5A5, 1, 32'hAAAA, 32'hBBBB, 0, 0, 16'd1));
    for (int i = 0; i < 3; i++)
      cyc(6'b011111, 0, 5'd3, 0, 32'h0, 0, 32'h1, 32'h2, 64'hFFFF, 2'd2,
          mk("hold", 5'd9, 1, 32'hA5A5A5A5, 1, 32'hAAAA, 32'hBBBB, 0, 0, 16'd1));
    cyc(6'b001111, 1, 5'd4, 1, 32'h4444, 1, 32'h1, 32'h2, 64'hCAFE_0000_BEEF_0000, 2'd3,
        mk("flush", 5'd0, 0, 0, 0, 0, 0, 0, 0, 16'd1));

    for (int i = 0; i < 65539; i++)
      cyc(6'b001111, 0, 5'd1, 1, 32'h1, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd2, skip);
    cyc(6'b001111, 0, 5'd1, 1, 32'h1, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd2,
        mk("sat", 5'd0, 0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd2, 16'hFFFF));
    cyc(6'b001111, 0, 5'd1, 1, 32'h1, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd2,
        mk("sat_hold", 5'd0, 0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd2, 16'hFFFF));

    // Reset asserted between edges while ex is still stalled.
    @(negedge clk);
    #1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_hold");
    #1;
    drive('0, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    cyc(6'b000000, 0, 5'd6, 1, 32'h12345678, 0, 0, 0, 64'hFFFF_FFFF, 2'd3,
        mk("post_rst", 5'd6, 1, 32'h12345678, 0, 0, 0, 0, 0, 16'd0));

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
